// File: rtl/video_pattern_pkg.sv
// Shared types and constants for the RGB test-pattern generator.
// Pixel words are packed {R,B,G} to match the downstream video-out stage.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int unsigned BAR_COUNT    = 8;
  localparam int unsigned CHECKER_LOG2 = 5;

  localparam logic [23:0] BAR_WHITE   = 24'hFF_FF_FF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFF_00_FF;
  localparam logic [23:0] BAR_CYAN    = 24'h00_FF_FF;
  localparam logic [23:0] BAR_GREEN   = 24'h00_00_FF;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF_FF_00;
  localparam logic [23:0] BAR_RED     = 24'hFF_00_00;
  localparam logic [23:0] BAR_BLUE    = 24'h00_FF_00;
  localparam logic [23:0] BAR_BLACK   = 24'h00_00_00;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_color.sv
// Combinational pixel colour for a given pattern and position.
// Only the bits each pattern actually needs are brought in (x[7:0], y bit 5).
module video_pattern_color
  import video_pattern_pkg::*;
(
  input  pattern_e    pattern,
  input  logic [7:0]  x_lo,
  input  logic        y_tile,
  input  logic [2:0]  bar_idx,
  input  logic [7:0]  frame_base,
  input  logic [23:0] solid,
  output logic [23:0] pixel
);

  logic [7:0] ramp;

  always_comb begin
    ramp  = x_lo + frame_base;
    pixel = '0;
    unique case (pattern)
      PAT_BARS:    pixel = bar_color(bar_idx);
      PAT_RAMP:    pixel = {ramp, ramp, ramp};
      PAT_CHECKER: pixel = (x_lo[CHECKER_LOG2] ^ y_tile) ? '1 : '0;
      PAT_SOLID:   pixel = solid;
      default:     pixel = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream RGB test-pattern source: one pixel per beat, tuser marks
// start of frame, tlast marks end of line. Config is latched per frame.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned XW    = $clog2(H_ACTIVE);
  localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BAR_W = H_ACTIVE / BAR_COUNT;
  localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  state_e      state;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [2:0]    bar_idx, nbar;
  logic [BW-1:0] bar_cnt, nbar_cnt;
  pattern_e      cfg_pat, npat;
  logic [23:0]   cfg_solid, nsolid;
  logic [7:0]    frame_base, nbase;

  logic handshake, x_last, y_last, frame_done;
  logic relatch, advance, prime, load;
  logic [7:0]  x_lo;
  logic        y_tile;
  logic [23:0] pixel;

  // Next-position and next-config mux; the colour block always sees the
  // coordinates that will be registered, so the pixel lands with them.
  always_comb begin
    handshake  = m_axis_tvalid & m_axis_tready;
    x_last     = (x == XW'(H_ACTIVE - 1));
    y_last     = (y == YW'(V_ACTIVE - 1));
    frame_done = handshake & x_last & y_last;
    relatch    = frame_done & enable;
    advance    = handshake & ~frame_done;
    prime      = (state == ST_ACTIVE) & ~m_axis_tvalid;
    load       = relatch | advance | prime;

    nx       = x;
    ny       = y;
    nbar     = bar_idx;
    nbar_cnt = bar_cnt;
    npat     = cfg_pat;
    nsolid   = cfg_solid;
    nbase    = frame_base;

    if (relatch) begin
      nx       = '0;
      ny       = '0;
      nbar     = '0;
      nbar_cnt = '0;
      npat     = pattern_e'(pattern_sel);
      nsolid   = solid_color;
      nbase    = frame_cnt + 8'd1;
    end else if (advance) begin
      if (x_last) begin
        nx       = '0;
        ny       = y + YW'(1);
        nbar     = '0;
        nbar_cnt = '0;
      end else begin
        nx = x + XW'(1);
        if (bar_cnt == BW'(BAR_W - 1)) begin
          nbar_cnt = '0;
          nbar     = bar_idx + 3'd1;
        end else begin
          nbar_cnt = bar_cnt + BW'(1);
        end
      end
    end
  end

  assign x_lo = 8'(nx);

  if (YW > CHECKER_LOG2) begin : g_ytile
    assign y_tile = ny[CHECKER_LOG2];
  end else begin : g_ytile_zero
    assign y_tile = 1'b0;
  end

  video_pattern_color u_color (
    .pattern    (npat),
    .x_lo       (x_lo),
    .y_tile     (y_tile),
    .bar_idx    (nbar),
    .frame_base (nbase),
    .solid      (nsolid),
    .pixel      (pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      bar_idx       <= '0;
      bar_cnt       <= '0;
      cfg_pat       <= PAT_BARS;
      cfg_solid     <= '0;
      frame_base    <= '0;
      frame_cnt     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_ACTIVE;
            x          <= '0;
            y          <= '0;
            bar_idx    <= '0;
            bar_cnt    <= '0;
            cfg_pat    <= pattern_e'(pattern_sel);
            cfg_solid  <= solid_color;
            frame_base <= frame_cnt;
          end
        end
        ST_ACTIVE: begin
          if (load) begin
            x             <= nx;
            y             <= ny;
            bar_idx       <= nbar;
            bar_cnt       <= nbar_cnt;
            cfg_pat       <= npat;
            cfg_solid     <= nsolid;
            frame_base    <= nbase;
            m_axis_tdata  <= pixel;
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= (nx == '0) && (ny == '0);
            m_axis_tlast  <= (nx == XW'(H_ACTIVE - 1));
          end else if (frame_done) begin
            state         <= ST_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_ACTIVE);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: expected frames are queued from a
// pixel-level reference model and popped by a monitor on every handshake.
module tb_video_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;
  localparam int FRAME = H * V;

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_color = '0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        busy;
  logic [7:0]  frame_cnt;

  int    vectors = 0;
  int    miscompares = 0;
  int    hs_cnt = 0;
  int    ready_mode = 0;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];

  video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .pattern_sel   (pattern_sel),
    .solid_color   (solid_color),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference colour from R,G,B rules, packed {R,B,G} for the bus.
  function automatic logic [23:0] model_pixel(input int pat, input logic [23:0] solid,
                                              input int base, input int x, input int y);
    logic [7:0] r, g, b;
    int bar;
    r = 8'h00; g = 8'h00; b = 8'h00;
    bar = x / (H / 8);
    case (pat)
      0: begin
        r = (bar inside {0, 1, 4, 5}) ? 8'hFF : 8'h00;
        g = (bar inside {0, 1, 2, 3}) ? 8'hFF : 8'h00;
        b = (bar inside {0, 2, 4, 6}) ? 8'hFF : 8'h00;
      end
      1: begin
        r = 8'((x + base) % 256);
        g = r;
        b = r;
      end
      2: begin
        r = (((x / 32) + (y / 32)) % 2 == 1) ? 8'hFF : 8'h00;
        g = r;
        b = r;
      end
      default: return solid;
    endcase
    return {r, b, g};
  endfunction

  task automatic push_frame(input int pat, input logic [23:0] solid, input int base);
    beat_t e;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        e.d = model_pixel(pat, solid, base, x, y);
        e.u = (x == 0) && (y == 0);
        e.l = (x == H - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target);
    int budget;
    budget = 3000;
    while (hs_cnt < target && budget > 0) begin
      tick();
      budget--;
    end
    if (hs_cnt < target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_hs: reached %0d handshakes, expected %0d", hs_cnt, target);
    end
  endtask

  // tready driver: 0 = held high, 1 = random 50%, other = held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: compare each handshaken beat with the queue, and hold checks while stalled.
  initial begin
    beat_t e, held;
    bit stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        vectors++;
        if (!(m_axis_tvalid && m_axis_tdata == held.d && m_axis_tuser == held.u
              && m_axis_tlast == held.l)) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b d=%h u=%b l=%b expected v=1 d=%h u=%b l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, held.d, held.u, held.l);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat %0d: got unexpected d=%h u=%b l=%b expected no beat",
                   hs_cnt, m_axis_tdata, m_axis_tuser, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
            miscompares++;
            $display("FAIL beat %0d: got d=%h u=%b l=%b expected d=%h u=%b l=%b",
                     hs_cnt, m_axis_tdata, m_axis_tuser, m_axis_tlast, e.d, e.u, e.l);
          end
        end
        hs_cnt++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = '{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast};
    end
  end

  initial begin
    int gaps, base_hs, pat, budget;
    logic [23:0] sc;

    tick();
    tick();
    check("rst_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_tdata", 32'(m_axis_tdata), 0);
    check("rst_tuser", 32'(m_axis_tuser), 0);
    check("rst_tlast", 32'(m_axis_tlast), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Bars, tready high: latency, gap-free frames, frame counter.
    pattern_sel = 2'd0;
    push_frame(0, '0, 0);
    push_frame(0, '0, 1);
    enable = 1'b1;
    tick();
    check("lat_busy", 32'(busy), 1);
    check("lat_tvalid_early", 32'(m_axis_tvalid), 0);
    tick();
    check("lat_tvalid", 32'(m_axis_tvalid), 1);
    check("lat_tuser", 32'(m_axis_tuser), 1);
    gaps = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (!m_axis_tvalid) gaps++;
      tick();
    end
    check("gap_cycles", 32'(gaps), 0);
    check("frame_cnt_1", 32'(frame_cnt), 1);
    check("next_frame_tvalid", 32'(m_axis_tvalid), 1);
    check("next_frame_tuser", 32'(m_axis_tuser), 1);

    // Ramp under random stalls; then solid change mid-frame; then drop enable mid-frame.
    pattern_sel = 2'd1;
    push_frame(1, '0, 2);
    push_frame(1, '0, 3);
    ready_mode = 1;
    wait_hs(3 * FRAME + 20);
    pattern_sel = 2'd3;
    solid_color = 24'h123456;
    push_frame(3, 24'h123456, 4);
    wait_hs(4 * FRAME + 20);
    enable = 1'b0;
    wait_hs(5 * FRAME);
    tick();
    tick();
    check("idle_tvalid", 32'(m_axis_tvalid), 0);
    check("idle_busy", 32'(busy), 0);
    check("frame_cnt_5", 32'(frame_cnt), 5);
    check("queue_drained", 32'(exp_q.size()), 0);

    // Reset mid-frame with tready low.
    ready_mode = 0;
    pattern_sel = 2'd1;
    base_hs = hs_cnt;
    push_frame(1, '0, 5);
    enable = 1'b1;
    wait_hs(base_hs + 30);
    ready_mode = 2;
    tick();
    tick();
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(m_axis_tvalid), 0);
    check("arst_tdata", 32'(m_axis_tdata), 0);
    check("arst_tuser", 32'(m_axis_tuser), 0);
    check("arst_tlast", 32'(m_axis_tlast), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_frame_cnt", 32'(frame_cnt), 0);
    exp_q.delete();

    // Release with enable high: one random-config frame from (0,0).
    pat = int'($urandom_range(0, 3));
    sc = 24'($urandom);
    pattern_sel = 2'(pat);
    solid_color = sc;
    ready_mode = 1;
    tick();
    push_frame(pat, sc, 0);
    base_hs = hs_cnt;
    mon_en = 1'b1;
    rst = 1'b0;
    budget = 20;
    while (!busy && budget > 0) begin
      tick();
      budget--;
    end
    check("restart_busy", 32'(busy), 1);
    enable = 1'b0;
    wait_hs(base_hs + FRAME);
    tick();
    tick();
    check("final_tvalid", 32'(m_axis_tvalid), 0);
    check("final_busy", 32'(busy), 0);
    check("final_frame_cnt", 32'(frame_cnt), 1);
    check("final_queue", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
